// File: rtl/fpu_sequencer_pkg.sv
// rtl/fpu_sequencer_pkg.sv - shared types, flag positions and helpers for the fpu sequencer
package pa_fpu;

    typedef enum logic {
        op_add = 1'b0,
        op_sub = 1'b1
    } e_fpu_op;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } e_seq_state;

    localparam int FLAG_NAN  = 3;
    localparam int FLAG_INF  = 2;
    localparam int FLAG_ZERO = 1;
    localparam int FLAG_SIGN = 0;

    localparam logic [31:0] QNAN = 32'h7fc00000;

    function automatic logic [3:0] result_flags(input logic [31:0] r);
        logic [3:0] f;
        f            = '0;
        f[FLAG_NAN]  = (r[30:23] == 8'hff) && (r[22:0] != 23'd0);
        f[FLAG_INF]  = (r[30:23] == 8'hff) && (r[22:0] == 23'd0);
        f[FLAG_ZERO] = (r[30:23] == 8'h00) && (r[22:0] == 23'd0);
        f[FLAG_SIGN] = r[31];
        return f;
    endfunction

endpackage

// File: rtl/fpu_sequencer_fpu.sv
// rtl/fpu_sequencer_fpu.sv - combinational single-precision add/sub, round-to-nearest-even
module fpu
    import pa_fpu::*;
(
    input  e_fpu_op     op,
    input  logic [31:0] ieee_a,
    input  logic [31:0] ieee_b,
    output logic [31:0] ieee_packet_out
);

    logic               sa, sb, sx, sy, a_big, eff_sub, rnd_up;
    logic               a_nan, b_nan, a_inf, b_inf;
    logic [7:0]         ea, eb, ex, ey, d;
    logic [23:0]        ma, mb, mx, my;
    logic [4:0]         dcap;
    logic [51:0]        x_full, y_full, sum, norm;
    logic [5:0]         p;
    logic [24:0]        mant_r;
    logic [22:0]        frac;
    logic signed [10:0] e_res;

    always_comb begin
        sa    = ieee_a[31];
        sb    = ieee_b[31] ^ (op == op_sub);
        ea    = ieee_a[30:23];
        eb    = ieee_b[30:23];
        a_nan = (ea == 8'hff) && (ieee_a[22:0] != 23'd0);
        b_nan = (eb == 8'hff) && (ieee_b[22:0] != 23'd0);
        a_inf = (ea == 8'hff) && (ieee_a[22:0] == 23'd0);
        b_inf = (eb == 8'hff) && (ieee_b[22:0] == 23'd0);
        // subnormal inputs are flushed to zero
        ma    = (ea == 8'd0) ? 24'd0 : {1'b1, ieee_a[22:0]};
        mb    = (eb == 8'd0) ? 24'd0 : {1'b1, ieee_b[22:0]};

        a_big   = ieee_a[30:0] >= ieee_b[30:0];
        sx      = a_big ? sa : sb;
        sy      = a_big ? sb : sa;
        ex      = a_big ? ea : eb;
        ey      = a_big ? eb : ea;
        mx      = a_big ? ma : mb;
        my      = a_big ? mb : ma;
        eff_sub = sx ^ sy;

        // beyond 27 places the small operand only acts as a sticky bit
        d      = ex - ey;
        dcap   = (d > 8'd27) ? 5'd27 : d[4:0];
        x_full = {1'b0, mx, 27'd0};
        y_full = {1'b0, my, 27'd0} >> dcap;
        sum    = eff_sub ? (x_full - y_full) : (x_full + y_full);

        p = '0;
        for (int i = 0; i < 52; i++) begin
            if (sum[i]) p = 6'(i);
        end
        norm   = sum << (6'd51 - p);
        rnd_up = norm[27] && ((|norm[26:0]) || norm[28]);
        mant_r = {1'b0, norm[51:28]} + {24'd0, rnd_up};
        frac   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
        e_res  = 11'(ex) + 11'(p) + 11'(mant_r[24]) - 11'd50;

        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb)))
            ieee_packet_out = QNAN;
        else if (a_inf)
            ieee_packet_out = {sa, 8'hff, 23'd0};
        else if (b_inf)
            ieee_packet_out = {sb, 8'hff, 23'd0};
        else if (sum == 52'd0)
            ieee_packet_out = {sa & sb, 31'd0};
        else if (e_res <= 0)
            ieee_packet_out = {sx, 31'd0};
        else if (e_res >= 255)
            ieee_packet_out = {sx, 8'hff, 23'd0};
        else
            ieee_packet_out = {sx, e_res[7:0], frac};
    end

endmodule

// File: rtl/fpu_sequencer.sv
// rtl/fpu_sequencer.sv - two-requester round-robin front end holding operands on the fpu until settled
module fpu_sequencer
    import pa_fpu::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  e_fpu_op     req_op [2],
    input  logic [31:0] req_a [2],
    input  logic [31:0] req_b [2],
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic [3:0]  rsp_flags,
    output logic        busy,
    output logic [15:0] ops_done
);

    e_seq_state  state, state_next;
    logic        grant, last_grant, accept;
    logic [3:0]  cnt;
    e_fpu_op     op_q;
    logic [31:0] a_q, b_q;
    logic        id_q;
    logic [31:0] ieee_packet_out;

    // last_grant resets to 1 so requester 0 wins the first contention
    always_comb begin
        if (req_valid == 2'b11) grant = ~last_grant;
        else                    grant = req_valid[1];
    end

    assign accept = (state == ST_IDLE) && req_valid[grant];
    assign rsp_id = id_q;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept)      state_next = ST_WAIT;
            ST_WAIT: if (cnt == 4'd0) state_next = ST_DONE;
            ST_DONE: if (rsp_ready)   state_next = ST_IDLE;
            default:                  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 2'b00;
        if (state == ST_IDLE) req_ready[grant] = 1'b1;
        busy      = (state != ST_IDLE);
        rsp_valid = (state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            cnt        <= '0;
            op_q       <= op_add;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            ops_done   <= '0;
        end else begin
            if (accept) begin
                last_grant <= grant;
                cnt        <= 4'(SETTLE_CYCLES - 1);
                op_q       <= req_op[grant];
                a_q        <= req_a[grant];
                b_q        <= req_b[grant];
                id_q       <= grant;
            end
            if (state == ST_WAIT) begin
                if (cnt == 4'd0) begin
                    rsp_result <= ieee_packet_out;
                    rsp_flags  <= result_flags(ieee_packet_out);
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end
            if (rsp_valid && rsp_ready) ops_done <= ops_done + 16'd1;
        end
    end

    fpu fpu_top (
        .op              (op_q),
        .ieee_a          (a_q),
        .ieee_b          (b_q),
        .ieee_packet_out (ieee_packet_out)
    );

endmodule

// File: tb/tb_fpu_sequencer.sv
// tb/tb_fpu_sequencer.sv - randomized and directed self-checking bench for fpu_sequencer
module tb_fpu_sequencer;
    import pa_fpu::*;

    localparam int SETTLE = 3;

    logic        clk, rst;
    logic [1:0]  req_valid, req_ready;
    e_fpu_op     req_op [2];
    logic [31:0] req_a [2];
    logic [31:0] req_b [2];
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic        busy;
    logic [15:0] ops_done;

    int          vectors = 0;
    int          fails = 0;
    logic [15:0] exp_ops;

    fpu_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .busy       (busy),
        .ops_done   (ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Exact integer sum of the two significands, then round-to-nearest-even to 24 bits.
    function automatic logic [31:0] ref_fpu(input e_fpu_op op, input logic [31:0] a, input logic [31:0] b);
        logic   sa, sb, sign;
        int     ea, eb, e, len, shift;
        longint ma, mb, va, vb, s, m, q, rem, half;
        sa = a[31];
        sb = b[31] ^ (op == op_sub);
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7fc00000;
        if (ea == 255 && eb == 255) return (sa == sb) ? {sa, 8'hff, 23'd0} : 32'h7fc00000;
        if (ea == 255) return {sa, 8'hff, 23'd0};
        if (eb == 255) return {sb, 8'hff, 23'd0};
        ma = (ea == 0) ? 64'sd0 : longint'({41'd1, a[22:0]});
        mb = (eb == 0) ? 64'sd0 : longint'({41'd1, b[22:0]});
        if (ea == 0) ea = eb;
        if (eb == 0) eb = ea;
        e  = (ea < eb) ? ea : eb;
        va = ma << (ea - e);
        vb = mb << (eb - e);
        if (sa) va = -va;
        if (sb) vb = -vb;
        s = va + vb;
        if (s == 0) return {sa & sb, 31'd0};
        sign = (s < 0);
        m    = sign ? -s : s;
        len  = 0;
        while ((m >> len) != 0) len++;
        if (len > 24) begin
            shift = len - 24;
            q     = m >> shift;
            rem   = m - (q << shift);
            half  = 64'sd1 << (shift - 1);
            if (rem > half || (rem == half && (q & 1) == 1)) q++;
            if (q == (64'sd1 << 24)) begin
                q = q >> 1;
                shift++;
            end
            e = e + shift;
        end else begin
            q = m << (24 - len);
            e = e - (24 - len);
        end
        return {sign, 8'(e), 23'(q)};
    endfunction

    function automatic logic [3:0] ref_flags(input logic [31:0] r);
        logic is_max_exp, is_zero_exp, frac_zero;
        is_max_exp  = (r[30:23] == 8'd255);
        is_zero_exp = (r[30:23] == 8'd0);
        frac_zero   = (r[22:0] == 23'd0);
        return {is_max_exp && !frac_zero, is_max_exp && frac_zero, is_zero_exp && frac_zero, r[31]};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        v[31]    = 1'($urandom_range(0, 1));
        v[30:23] = 8'($urandom_range(120, 134));
        v[22:0]  = 23'($urandom);
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_op(input int id, input e_fpu_op op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input logic [3:0] exp_f, input int hold);
        int   lat;
        logic idb;
        idb = id[0];
        @(negedge clk);
        req_valid      = 2'b00;
        req_valid[idb] = 1'b1;
        req_op[idb]    = op;
        req_a[idb]     = a;
        req_b[idb]     = b;
        rsp_ready      = 1'b0;
        #1;
        check("req_ready", 64'(req_ready), idb ? 64'd2 : 64'd1);
        @(negedge clk);
        req_valid = 2'b00;
        for (int i = 0; i < 2; i++) begin
            req_a[i]  = $urandom;
            req_b[i]  = $urandom;
            req_op[i] = e_fpu_op'($urandom_range(0, 1));
        end
        check("busy_wait", 64'(busy), 64'd1);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'(SETTLE));
        check("result", 64'(rsp_result), 64'(exp_r));
        check("rsp_id", 64'(rsp_id), 64'(idb));
        check("flags", 64'(rsp_flags), 64'(exp_f));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold", 64'({rsp_valid, busy, req_ready, rsp_id, rsp_flags, rsp_result}),
                  64'({1'b1, 1'b1, 2'b00, idb, exp_f, exp_r}));
        end
        rsp_ready = 1'b1;
        exp_ops   = exp_ops + 16'd1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("idle_after", 64'({busy, rsp_valid}), 64'd0);
        check("ops_done", 64'(ops_done), 64'(exp_ops));
    endtask

    initial begin
        int          nresp, ngrant, cyc, last_acc, id;
        e_fpu_op     op;
        logic [31:0] a, b, r;

        rst       = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_op[i] = op_add;
            req_a[i]  = '0;
            req_b[i]  = '0;
        end
        exp_ops = 16'd0;
        do_reset();
        check("reset", 64'({rsp_valid, busy, rsp_id, rsp_flags, rsp_result, ops_done}), 64'd0);

        run_op(0, op_add, 32'h3f800000, 32'h3f8ccccd, 32'h40066666, 4'b0000, 0);
        run_op(1, op_sub, 32'h7f800000, 32'h7f800000, 32'h7fc00000, 4'b1000, 1);
        run_op(0, op_add, 32'hc0000000, 32'h40000000, 32'h00000000, 4'b0010, 10);
        run_op(1, op_add, 32'h7f800000, 32'h3f800000, 32'h7f800000, 4'b0100, 0);
        run_op(0, op_sub, 32'h3f800000, 32'h40000000, 32'hbf800000, 4'b0001, 2);

        for (int k = 0; k < 12; k++) begin
            id = int'($urandom_range(0, 1));
            op = e_fpu_op'($urandom_range(0, 1));
            a  = rand_fp();
            b  = rand_fp();
            if ($urandom_range(0, 3) == 0) b = (op == op_sub) ? a : {~a[31], a[30:0]};
            r  = ref_fpu(op, a, b);
            run_op(id, op, a, b, r, ref_flags(r), int'($urandom_range(0, 2)));
        end

        // reset while waiting: no response, then contention starts with requester 0
        @(negedge clk);
        req_valid = 2'b01;
        req_op[0] = op_add;
        req_a[0]  = rand_fp();
        req_b[0]  = rand_fp();
        @(negedge clk);
        req_valid = 2'b00;
        check("busy_before_rst", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        exp_ops = 16'd0;
        for (int i = 0; i < SETTLE + 4; i++) begin
            check("no_rsp_after_rst", 64'({rsp_valid, busy}), 64'd0);
            @(negedge clk);
        end
        check("ops_after_rst", 64'(ops_done), 64'd0);

        req_op[0] = op_add;
        req_a[0]  = 32'h41800000;
        req_b[0]  = 32'h42000000;
        req_op[1] = op_sub;
        req_a[1]  = 32'h3f000000;
        req_b[1]  = 32'h3e800000;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        #1;
        nresp    = 0;
        ngrant   = 0;
        cyc      = 0;
        last_acc = -1;
        while (nresp < 4 && cyc < 100) begin
            if ((req_ready & req_valid) != 2'b00) begin
                if (ngrant < 4) check("rr_grant", 64'(req_ready), (ngrant % 2 == 1) ? 64'd2 : 64'd1);
                if (last_acc >= 0) check("rr_gap", 64'(cyc - last_acc), 64'(SETTLE + 2));
                last_acc = cyc;
                ngrant++;
            end
            if (rsp_valid) begin
                check("rr_id", 64'(rsp_id), 64'(nresp % 2));
                check("rr_result", 64'(rsp_result), (nresp % 2 == 1) ? 64'h3e800000 : 64'h42400000);
                nresp++;
                exp_ops = exp_ops + 16'd1;
                if (nresp == 4) req_valid = 2'b00;
            end
            @(negedge clk);
            cyc++;
        end
        rsp_ready = 1'b0;
        check("rr_count", 64'(nresp), 64'd4);
        check("rr_ops", 64'(ops_done), 64'(exp_ops));

        @(negedge clk);
        force dut.ops_done = 16'hffff;
        @(negedge clk);
        release dut.ops_done;
        exp_ops = 16'hffff;
        run_op(0, op_add, 32'h3f800000, 32'h3f800000, 32'h40000000, 4'b0000, 0);
        check("ops_wrap", 64'(ops_done), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
